// File: rtl/word_memory.sv
// Single-port DEPTH x WIDTH word store with a zeroing sweep after reset or on request.
// Reads return one cycle after acceptance; requests are ignored while the sweep runs.
module word_memory #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              select,
    input  logic              RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  input_word,
    input  logic              clear,
    output logic [WIDTH-1:0]  output_word,
    output logic              out_valid,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              addr_ok_c;
    logic              accept_c;
    logic              wr_en_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [WIDTH-1:0]  wr_data_c;

    // Addresses at or beyond DEPTH are legal on the port but map to no storage.
    assign addr_ok_c = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign accept_c  = (state == IDLE) && select && !clear;

    // Single write port shared between the sweep and host writes.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_idx_c  = '0;
        wr_data_c = '0;
        if (state == CLEAR) begin
            wr_en_c  = 1'b1;
            wr_idx_c = ptr;
        end else if (accept_c && !RW && addr_ok_c) begin
            wr_en_c   = 1'b1;
            wr_idx_c  = IDX_W'(addr);
            wr_data_c = input_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en_c) begin
            mem[wr_idx_c] <= wr_data_c;
        end
    end

    // Control FSM plus registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= CLEAR;
            ptr         <= '0;
            busy        <= 1'b1;
            out_valid   <= 1'b0;
            output_word <= '0;
        end else begin
            out_valid   <= 1'b0;
            output_word <= '0;
            case (state)
                CLEAR: begin
                    ptr <= ptr + IDX_W'(1);
                    if (ptr == IDX_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end else if (select && RW) begin
                        out_valid   <= 1'b1;
                        output_word <= addr_ok_c ? mem[IDX_W'(addr)] : '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_memory.sv
// Scoreboard bench for word_memory: default 16-word instance and a 12-word instance
// with a 4-bit address to exercise out-of-range addresses.
module tb_word_memory;

    logic       clk = 1'b0;
    logic       rst_n, select, rw, clr;
    logic [3:0] addr, din;
    logic [3:0] dout;
    logic       out_valid, busy;

    logic       rst2_n, select2, rw2, clr2;
    logic [3:0] addr2, din2;
    logic [3:0] dout2;
    logic       out_valid2, busy2;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [3:0] q16[$];
    logic [3:0] q12[$];

    always #5 clk = ~clk;

    word_memory u_d16 (
        .clk(clk), .rst_n(rst_n), .select(select), .RW(rw), .addr(addr),
        .input_word(din), .clear(clr), .output_word(dout),
        .out_valid(out_valid), .busy(busy)
    );

    word_memory #(.WIDTH(4), .DEPTH(12), .ADDR_W(4)) u_d12 (
        .clk(clk), .rst_n(rst2_n), .select(select2), .RW(rw2), .addr(addr2),
        .input_word(din2), .clear(clr2), .output_word(dout2),
        .out_valid(out_valid2), .busy(busy2)
    );

    // Monitors: every valid output pops one expected word; idle cycles must show zero.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (out_valid === 1'b1) begin
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL d16_unexpected_valid got=%h required=no out_valid", dout);
                end else begin
                    logic [3:0] exp;
                    exp = q16.pop_front();
                    if (dout !== exp) begin
                        errors++;
                        $display("FAIL d16_read_data got=%h required=%h", dout, exp);
                    end
                end
            end else if (out_valid !== 1'b0 || dout !== 4'h0) begin
                errors++;
                $display("FAIL d16_idle_output got valid=%b word=%h required valid=0 word=0", out_valid, dout);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (out_valid2 === 1'b1) begin
                if (q12.size() == 0) begin
                    errors++;
                    $display("FAIL d12_unexpected_valid got=%h required=no out_valid", dout2);
                end else begin
                    logic [3:0] exp;
                    exp = q12.pop_front();
                    if (dout2 !== exp) begin
                        errors++;
                        $display("FAIL d12_read_data got=%h required=%h", dout2, exp);
                    end
                end
            end else if (out_valid2 !== 1'b0 || dout2 !== 4'h0) begin
                errors++;
                $display("FAIL d12_idle_output got valid=%b word=%h required valid=0 word=0", out_valid2, dout2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Counts cycles with busy high, bounded so a stuck sweep still reaches the summary.
    task automatic wait_busy(input bit d12, input int exp_n, input string name);
        int n = 0;
        while (((d12 ? busy2 : busy) === 1'b1) && n < 100) begin
            n++;
            tick();
        end
        check(name, n, exp_n);
    endtask

    task automatic wr16(input logic [3:0] a, input logic [3:0] d);
        select = 1'b1; rw = 1'b0; addr = a; din = d;
        tick();
        select = 1'b0;
    endtask

    task automatic rd16(input logic [3:0] a, input logic [3:0] exp);
        select = 1'b1; rw = 1'b1; addr = a;
        q16.push_back(exp);
        tick();
        select = 1'b0;
    endtask

    task automatic wr12(input logic [3:0] a, input logic [3:0] d);
        select2 = 1'b1; rw2 = 1'b0; addr2 = a; din2 = d;
        tick();
        select2 = 1'b0;
    endtask

    task automatic rd12(input logic [3:0] a, input logic [3:0] exp);
        select2 = 1'b1; rw2 = 1'b1; addr2 = a;
        q12.push_back(exp);
        tick();
        select2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; select = 1'b0; rw = 1'b0; clr = 1'b0; addr = '0; din = '0;
        rst2_n = 1'b0; select2 = 1'b0; rw2 = 1'b0; clr2 = 1'b0; addr2 = '0; din2 = '0;
        tick();
        mon_en = 1'b1;

        // Reset state
        check("reset_busy", int'(busy), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_output_word", int'(dout), 0);
        rst_n = 1'b1;
        wait_busy(1'b0, 16, "init_sweep_len");

        // Every word reads zero after the sweep, one read per cycle
        for (int i = 0; i < 16; i++) rd16(4'(i), 4'h0);
        tick();

        // Write then read next cycle
        wr16(4'd3, 4'hA);
        rd16(4'd3, 4'hA);
        tick();

        // Back-to-back pipelined reads
        wr16(4'd0, 4'h1);
        wr16(4'd1, 4'h2);
        wr16(4'd2, 4'h3);
        rd16(4'd0, 4'h1);
        rd16(4'd1, 4'h2);
        rd16(4'd2, 4'h3);
        tick();

        // Clear wins over a simultaneous write; requests and clear ignored during sweep
        wr16(4'd5, 4'hF);
        select = 1'b1; rw = 1'b0; addr = 4'd6; din = 4'h9; clr = 1'b1;
        tick();
        begin
            int n = 0;
            while (busy === 1'b1 && n < 100) begin
                select = 1'b1; rw = n[0]; addr = 4'(n); din = 4'hC; clr = 1'b1;
                n++;
                tick();
            end
            select = 1'b0; clr = 1'b0;
            check("clear_sweep_len", n, 16);
        end
        rd16(4'd5, 4'h0);
        rd16(4'd6, 4'h0);
        rd16(4'd3, 4'h0);
        tick();

        // Reset beats a simultaneous read; then reset again mid-sweep
        wr16(4'd7, 4'h4);
        select = 1'b1; rw = 1'b1; addr = 4'd7; rst_n = 1'b0;
        tick();
        select = 1'b0; rst_n = 1'b1;
        check("rst_read_dropped", int'(out_valid), 0);
        check("rst_busy", int'(busy), 1);
        repeat (7) tick();
        check("mid_sweep_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_busy(1'b0, 16, "restart_sweep_len");
        rd16(4'd7, 4'h0);
        tick();

        // 12-word instance: out-of-range write discarded, read returns zero
        rst2_n = 1'b1;
        wait_busy(1'b1, 12, "d12_sweep_len");
        wr12(4'd11, 4'h7);
        wr12(4'd13, 4'h7);
        rd12(4'd13, 4'h0);
        rd12(4'd11, 4'h7);
        rd12(4'd0, 4'h0);
        tick();
        tick();

        check("d16_pending_reads", q16.size(), 0);
        check("d12_pending_reads", q12.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_memory.md
WORD_MEMORY -- requirements
Module: word_memory

Interface
REQ-001 Parameter WIDTH, default 4: bits per stored word.
REQ-002 Parameter DEPTH, default 16: number of words (2..256).
REQ-003 Parameter ADDR_W, default 4: address width, SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 clk  input  1: sole clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 select  input  1: request strobe; sampled only when busy=0.
REQ-007 RW  input  1: 1 = read, 0 = write.
REQ-008 addr  input  ADDR_W: word address of request.
REQ-009 input_word  input  WIDTH: write data.
REQ-010 clear  input  1: request full-array zeroing sweep.
REQ-011 output_word  output  WIDTH: read data, zero when out_valid=0.
REQ-012 out_valid  output  1: output_word holds read result this cycle.
REQ-013 busy  output  1: clear sweep in progress; requests ignored.

Function
REQ-014 Block SHALL be a single-port synchronous array of DEPTH x WIDTH storage, governed by a two-state FSM: CLEAR, IDLE.
REQ-015 In CLEAR, a sweep pointer SHALL write zero to word 0,1,...,DEPTH-1, one word per cycle; busy=1 throughout.
REQ-016 CLEAR -> IDLE SHALL occur on the edge that zeroes word DEPTH-1; busy=0 from the following cycle, so CLEAR lasts exactly DEPTH cycles.
REQ-017 IDLE -> CLEAR SHALL occur when clear=1 sampled in IDLE; sweep restarts at word 0.
REQ-018 clear and select both 1 in IDLE: clear SHALL win; the request is dropped.
REQ-019 clear=1 while busy=1 SHALL be ignored (sweep neither restarts nor extends).
REQ-020 Write: select=1, RW=0, IDLE, no clear -> word[addr] <= input_word at that edge; out_valid stays 0.
REQ-021 Read: select=1, RW=1, IDLE, no clear -> next cycle out_valid=1, output_word = word[addr]; latency exactly 1 cycle.
REQ-022 Reads SHALL be fully pipelined: one read accepted per cycle; N consecutive read cycles give N consecutive out_valid=1 cycles.
REQ-023 out_valid SHALL be 1 for exactly one cycle per accepted read; otherwise 0 and output_word = 0.
REQ-024 Read of address written on the previous edge SHALL return the new data.
REQ-025 addr >= DEPTH: write SHALL be discarded with no array change; read SHALL return output_word=0 with out_valid=1.
REQ-026 select=1 while busy=1 SHALL be ignored entirely: no write, no out_valid.
REQ-027 A read accepted on the edge that enters CLEAR is impossible per REQ-018; a read accepted in the last IDLE cycle SHALL still produce its out_valid during the first CLEAR cycle.

Reset
REQ-028 rst_n=0 sampled at an edge SHALL set out_valid=0, output_word=0, sweep pointer=0, FSM=CLEAR, busy=1.
REQ-029 After rst_n returns to 1, the sweep SHALL run per REQ-015/016; array contents are zero once busy falls.
REQ-030 rst_n=0 during a sweep SHALL restart it at word 0; any in-flight read result SHALL be discarded (out_valid=0).
REQ-031 rst_n=0 SHALL take priority over every other input.

Verification
REQ-032 Reset release (defaults): busy=1 for exactly 16 cycles, then 0; read of every address returns 0x0, out_valid=1 one cycle after each.
REQ-033 Write 0xA to addr 3, next cycle read addr 3 -> following cycle output_word=0xA, out_valid=1; then out_valid=0, output_word=0.
REQ-034 Write 0x1,0x2,0x3 to addr 0,1,2; read addr 0,1,2 on consecutive cycles -> three consecutive out_valid cycles returning 0x1,0x2,0x3.
REQ-035 Write 0xF to addr 5, assert clear with select=1 RW=0 addr=6 same cycle -> busy=1 for 16 cycles, select during sweep ignored; afterwards addr 5 and 6 read 0x0.
REQ-036 Pull rst_n low for one cycle at sweep cycle 7 -> busy remains 1 for a further 16 cycles after release.
REQ-037 DEPTH=12, ADDR_W=4: write 0x7 to addr 13 -> no effect; read addr 13 -> output_word=0x0, out_valid=1; addr 11 retains prior value.
